// File: rtl/prf_mp.sv
// Physical register file with valid tracking, multi-port CDB writeback,
// invalidate ports, flush restore and duplicate-writeback detection.
// Optional feature: define PRF_MP_BYPASS_EN to forward same-cycle writeback
// data to matching read ports.
module prf_mp #(
    parameter int XLEN_P   = 32,
    parameter int N_PHYS   = 64,
    parameter int TAG_W    = 6,
    parameter int NUM_READ = 4,
    parameter int NUM_WB   = 2,
    parameter int NUM_INV  = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_INV-1:0]           inv_valid_i,
    input  logic [NUM_INV*TAG_W-1:0]     inv_tag_i,
    input  logic [NUM_WB-1:0]            wb_valid_i,
    input  logic [NUM_WB*TAG_W-1:0]      wb_tag_i,
    input  logic [NUM_WB*XLEN_P-1:0]     wb_data_i,
    input  logic                         flush_i,
    input  logic [N_PHYS-1:0]            restore_valid_i,
    input  logic [NUM_READ*TAG_W-1:0]    rtag_i,
    output logic [NUM_READ*XLEN_P-1:0]   rdata_o,
    output logic [NUM_READ-1:0]          rready_o,
    output logic [N_PHYS-1:0]            valid_o,
    output logic [TAG_W:0]               num_valid_o,
    output logic                         wb_conflict_o
);

    logic [XLEN_P-1:0] mem [N_PHYS];
    logic [N_PHYS-1:0] valid_next;
    logic [TAG_W:0]    count_next;
    logic              conflict_next;

    // A tag addresses real storage only if nonzero and inside the file;
    // the zero-extension keeps the range check meaningful for any TAG_W.
    function automatic logic tag_ok(input logic [TAG_W-1:0] t);
        return (t != '0) && ({1'b0, t} < (TAG_W+1)'(N_PHYS));
    endfunction

    // Next valid vector: flush restore or invalidates first, writebacks on top, reg 0 pinned.
    always_comb begin
        valid_next    = valid_o;
        conflict_next = 1'b0;
        count_next    = '0;
        if (flush_i) begin
            valid_next = restore_valid_i;
        end else begin
            for (int i = 0; i < NUM_INV; i++) begin
                if (inv_valid_i[i] && tag_ok(inv_tag_i[i*TAG_W +: TAG_W]))
                    valid_next[inv_tag_i[i*TAG_W +: TAG_W]] = 1'b0;
            end
        end
        for (int w = 0; w < NUM_WB; w++) begin
            if (wb_valid_i[w] && tag_ok(wb_tag_i[w*TAG_W +: TAG_W]))
                valid_next[wb_tag_i[w*TAG_W +: TAG_W]] = 1'b1;
        end
        for (int i = 0; i < NUM_WB; i++) begin
            for (int j = i + 1; j < NUM_WB; j++) begin
                if (wb_valid_i[i] && wb_valid_i[j] &&
                    tag_ok(wb_tag_i[i*TAG_W +: TAG_W]) &&
                    (wb_tag_i[i*TAG_W +: TAG_W] == wb_tag_i[j*TAG_W +: TAG_W]))
                    conflict_next = 1'b1;
            end
        end
        valid_next[0] = 1'b1;
        for (int k = 0; k < N_PHYS; k++)
            count_next = count_next + (TAG_W+1)'(valid_next[k]);
    end

    // Control state: valid bits, their population count and the conflict pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o       <= {{(N_PHYS-1){1'b0}}, 1'b1};
            num_valid_o   <= (TAG_W+1)'(1);
            wb_conflict_o <= 1'b0;
        end else begin
            valid_o       <= valid_next;
            num_valid_o   <= count_next;
            wb_conflict_o <= conflict_next;
        end
    end

    // Storage writes; later ports overwrite earlier ones so the highest index wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_PHYS; k++)
                mem[k] <= '0;
        end else begin
            for (int w = 0; w < NUM_WB; w++) begin
                if (wb_valid_i[w] && tag_ok(wb_tag_i[w*TAG_W +: TAG_W]))
                    mem[wb_tag_i[w*TAG_W +: TAG_W]] <= wb_data_i[w*XLEN_P +: XLEN_P];
            end
        end
    end

    // Read ports: tag 0 is a hard zero that is always ready.
    always_comb begin
        rdata_o  = '0;
        rready_o = '0;
        for (int r = 0; r < NUM_READ; r++) begin
            if (rtag_i[r*TAG_W +: TAG_W] == '0) begin
                rready_o[r] = 1'b1;
            end else if (tag_ok(rtag_i[r*TAG_W +: TAG_W])) begin
                rdata_o[r*XLEN_P +: XLEN_P] = mem[rtag_i[r*TAG_W +: TAG_W]];
                rready_o[r]                 = valid_o[rtag_i[r*TAG_W +: TAG_W]];
            end
`ifdef PRF_MP_BYPASS_EN
            for (int w = 0; w < NUM_WB; w++) begin
                if (wb_valid_i[w] && tag_ok(wb_tag_i[w*TAG_W +: TAG_W]) &&
                    (wb_tag_i[w*TAG_W +: TAG_W] == rtag_i[r*TAG_W +: TAG_W])) begin
                    rdata_o[r*XLEN_P +: XLEN_P] = wb_data_i[w*XLEN_P +: XLEN_P];
                    rready_o[r]                 = 1'b1;
                end
            end
`else
            // Writebacks become visible through storage on the following cycle.
`endif
        end
    end

endmodule

// File: tb/tb_prf_mp.sv
// Directed bench for prf_mp with a queue-based scoreboard of expected values.
module tb_prf_mp;

    localparam int XLEN_P   = 32;
    localparam int N_PHYS   = 64;
    localparam int TAG_W    = 6;
    localparam int NUM_READ = 4;
    localparam int NUM_WB   = 2;
    localparam int NUM_INV  = 2;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic [NUM_INV-1:0]          inv_valid_i;
    logic [NUM_INV*TAG_W-1:0]    inv_tag_i;
    logic [NUM_WB-1:0]           wb_valid_i;
    logic [NUM_WB*TAG_W-1:0]     wb_tag_i;
    logic [NUM_WB*XLEN_P-1:0]    wb_data_i;
    logic                        flush_i;
    logic [N_PHYS-1:0]           restore_valid_i;
    logic [NUM_READ*TAG_W-1:0]   rtag_i;
    logic [NUM_READ*XLEN_P-1:0]  rdata_o;
    logic [NUM_READ-1:0]         rready_o;
    logic [N_PHYS-1:0]           valid_o;
    logic [TAG_W:0]              num_valid_o;
    logic                        wb_conflict_o;

    int compared   = 0;
    int mismatched = 0;

    logic [63:0] exp_q[$];
    string       name_q[$];

    prf_mp #(
        .XLEN_P(XLEN_P), .N_PHYS(N_PHYS), .TAG_W(TAG_W),
        .NUM_READ(NUM_READ), .NUM_WB(NUM_WB), .NUM_INV(NUM_INV)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .inv_valid_i(inv_valid_i), .inv_tag_i(inv_tag_i),
        .wb_valid_i(wb_valid_i), .wb_tag_i(wb_tag_i), .wb_data_i(wb_data_i),
        .flush_i(flush_i), .restore_valid_i(restore_valid_i),
        .rtag_i(rtag_i), .rdata_o(rdata_o), .rready_o(rready_o),
        .valid_o(valid_o), .num_valid_o(num_valid_o), .wb_conflict_o(wb_conflict_o)
    );

    always #5 clk = ~clk;

    task automatic push(input string name, input logic [63:0] val);
        name_q.push_back(name);
        exp_q.push_back(val);
    endtask

    task automatic check(input logic [63:0] obs);
        logic [63:0] e;
        string       n;
        compared++;
        if (exp_q.size() == 0) begin
            mismatched++;
            $error("FAIL scoreboard_empty observed=%0h required=<queued value>", obs);
        end else begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            assert (obs === e) else begin
                mismatched++;
                $error("FAIL %s observed=%0h required=%0h", n, obs, e);
            end
        end
    endtask

    function automatic logic [XLEN_P-1:0] rd(input int r);
        return rdata_o[r*XLEN_P +: XLEN_P];
    endfunction

    task automatic clear_inputs();
        inv_valid_i     = '0;
        inv_tag_i       = '0;
        wb_valid_i      = '0;
        wb_tag_i        = '0;
        wb_data_i       = '0;
        flush_i         = 1'b0;
        restore_valid_i = '0;
    endtask

    task automatic set_wb(input int p, input int tag, input logic [XLEN_P-1:0] data);
        wb_valid_i[p]                = 1'b1;
        wb_tag_i[p*TAG_W +: TAG_W]   = TAG_W'(tag);
        wb_data_i[p*XLEN_P +: XLEN_P] = data;
    endtask

    task automatic set_inv(input int p, input int tag);
        inv_valid_i[p]              = 1'b1;
        inv_tag_i[p*TAG_W +: TAG_W] = TAG_W'(tag);
    endtask

    task automatic set_rtag(input int r, input int tag);
        rtag_i[r*TAG_W +: TAG_W] = TAG_W'(tag);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        rtag_i = '0;
        clear_inputs();
        // Activity presented while reset is held must be discarded.
        set_wb(0, 5, 32'hBAD0_0005);
        set_rtag(0, 5);
        set_rtag(1, 0);
        step();
        step();
        clear_inputs();
        rst_n = 1'b1;
        #1;

        // Reset state
        push("reset_valid", 64'h1);
        push("reset_count", 64'd1);
        push("reset_conflict", 64'd0);
        push("reset_rdata5", 64'd0);
        push("reset_rready5", 64'd0);
        push("reset_rready_tag0", 64'd1);
        check(valid_o);
        check(64'(num_valid_o));
        check(64'(wb_conflict_o));
        check(64'(rd(0)));
        check(64'(rready_o[0]));
        check(64'(rready_o[1]));

        // Single writeback
        set_wb(0, 5, 32'hDEAD_BEEF);
        push("write_rdata5", 64'hDEAD_BEEF);
        push("write_rready5", 64'd1);
        push("write_count", 64'd2);
        push("write_valid", 64'h21);
        step();
        clear_inputs();
        check(64'(rd(0)));
        check(64'(rready_o[0]));
        check(64'(num_valid_o));
        check(valid_o);

        // Duplicate writeback tags
        set_wb(0, 7, 32'h11);
        set_wb(1, 7, 32'h22);
        push("collide_conflict", 64'd1);
        push("collide_rdata7", 64'h22);
        push("collide_count", 64'd3);
        step();
        clear_inputs();
        set_rtag(1, 7);
        #1;
        check(64'(wb_conflict_o));
        check(64'(rd(1)));
        check(64'(num_valid_o));
        push("collide_pulse_end", 64'd0);
        step();
        check(64'(wb_conflict_o));

        // Writeback beats invalidate; invalidating tag 0 has no effect
        set_inv(0, 5);
        set_inv(1, 0);
        set_wb(0, 5, 32'h33);
        push("prio_valid", 64'hA1);
        push("prio_rdata5", 64'h33);
        push("prio_count", 64'd3);
        step();
        clear_inputs();
        check(valid_o);
        check(64'(rd(0)));
        check(64'(num_valid_o));

        // Plain invalidate
        set_inv(0, 7);
        push("inv_rready7", 64'd0);
        push("inv_valid", 64'h21);
        push("inv_count", 64'd2);
        step();
        clear_inputs();
        check(64'(rready_o[1]));
        check(valid_o);
        check(64'(num_valid_o));

        // Flush restore with a same-cycle writeback; invalidates ignored
        flush_i         = 1'b1;
        restore_valid_i = '0;
        set_inv(0, 9);
        set_wb(0, 9, 32'h44);
        push("flush_valid", 64'h201);
        push("flush_count", 64'd2);
        push("flush_rdata9", 64'h44);
        push("flush_rready9", 64'd1);
        push("flush_rdata5_kept", 64'h33);
        push("flush_rready5", 64'd0);
        step();
        clear_inputs();
        set_rtag(2, 9);
        #1;
        check(valid_o);
        check(64'(num_valid_o));
        check(64'(rd(2)));
        check(64'(rready_o[2]));
        check(64'(rd(0)));
        check(64'(rready_o[0]));

        // Flush restore with a nonzero vector, bit 0 forced
        flush_i         = 1'b1;
        restore_valid_i = 64'h30;
        push("flush2_valid", 64'h31);
        push("flush2_count", 64'd3);
        step();
        clear_inputs();
        check(valid_o);
        check(64'(num_valid_o));

        // Register 0 is never written
        set_wb(0, 0, 32'hFF);
        set_rtag(3, 0);
        push("zero_rdata", 64'd0);
        push("zero_rready", 64'd1);
        push("zero_count", 64'd3);
        step();
        clear_inputs();
        check(64'(rd(3)));
        check(64'(rready_o[3]));
        check(64'(num_valid_o));

        // Same-cycle read of a tag being written
        set_wb(0, 3, 32'h55);
        set_rtag(3, 3);
`ifdef PRF_MP_BYPASS_EN
        push("bypass_rdata", 64'h55);
        push("bypass_rready", 64'd1);
`else
        push("bypass_rdata", 64'd0);
        push("bypass_rready", 64'd0);
`endif
        #1;
        check(64'(rd(3)));
        check(64'(rready_o[3]));
        push("after_rdata3", 64'h55);
        push("after_rready3", 64'd1);
        step();
        clear_inputs();
        check(64'(rd(3)));
        check(64'(rready_o[3]));

        // Asynchronous reset mid-run clears storage and valid state at once
        #2;
        rst_n = 1'b0;
        #1;
        push("areset_valid", 64'h1);
        push("areset_count", 64'd1);
        push("areset_rdata3", 64'd0);
        check(valid_o);
        check(64'(num_valid_o));
        check(64'(rd(3)));
        rst_n = 1'b1;

        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $error("FAIL scoreboard_leftover observed=%0d required=0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
